// File: rtl/rr_arbiter8_pkg.sv
// Shared widths, FSM state type and vector rotation helper for rr_arbiter8.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Rotate right by sh: result bit i is v[(i + sh) mod N_REQ], so bit 0 of
    // the result corresponds to requester sh.
    function automatic logic [N_REQ-1:0] rot_vec(input logic [N_REQ-1:0] v,
                                                 input logic [IDX_W-1:0] sh);
        logic [N_REQ-1:0] r;
        logic [IDX_W-1:0] k;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k    = IDX_W'(i) + sh;
            r[i] = v[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// Latency: n/a (wires only).
// Backpressure: none; grant holding is the only flow control.
// Ports: req, mask, done (requester side) ; gnt, gnt_idx, gnt_valid, timeout (arbiter side).
interface rr_arbiter8_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, mask, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, mask, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_arbiter8_enc.sv
// One-hot to binary index encoder for the 8-bit grant vector.
// Latency: combinational.
// Backpressure: none.
// Ports: vec (one-hot or zero in), idx (binary index, 0 for zero vec), vld (vec nonzero).
module onehot_enc8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // OR of indices is exact for one-hot input and yields 0 for an empty vector.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign vld = |vec;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with done/drop/hold-limit release.
// Latency: grant registered one edge after a nonzero effective request; release one edge after its cause.
// Backpressure: a grant is held until done, request drop/mask, or MAX_HOLD cycles; one idle cycle between grants.
// Ports: clk, rst (async active-high), bus (slave side of rr_arbiter8_if).
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter8_if.slave   bus
);

    localparam int               CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD < 1) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam bit               TO_EN    = (MAX_HOLD > 0);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             vld_q;
    logic             to_q;

    logic [N_REQ-1:0] eff;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] win;
    logic [IDX_W-1:0] unrot_sh;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_to;
    logic             rel;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             vld_nxt;

    assign eff = bus.req & ~bus.mask;

    // Rotate so the pointer position lands on bit 0, take the lowest set bit,
    // then rotate back by -ptr to recover the requester position.
    assign rot      = rot_vec(eff, ptr);
    assign pick     = rot & (~rot + {{(N_REQ-1){1'b0}}, 1'b1});
    assign unrot_sh = ~ptr + {{(IDX_W-1){1'b0}}, 1'b1};
    assign win      = rot_vec(pick, unrot_sh);

    assign rel_done = bus.done;
    assign rel_drop = ~eff[idx_q];
    assign rel_to   = TO_EN && (cnt == CNT_LAST);
    assign rel      = (state == BUSY) && (rel_done || rel_drop || rel_to);

    always_comb begin
        gnt_nxt = gnt_q;
        if (state == IDLE) begin
            gnt_nxt = win;
        end else if (rel) begin
            gnt_nxt = '0;
        end
    end

    onehot_enc8 u_enc (
        .vec (gnt_nxt),
        .idx (idx_nxt),
        .vld (vld_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            gnt_q <= gnt_nxt;
            idx_q <= idx_nxt;
            vld_q <= vld_nxt;
            // Done or drop take precedence: a hold-limit release only pulses
            // timeout when it is the sole cause.
            to_q  <= (state == BUSY) && rel_to && !rel_done && !rel_drop;
            case (state)
                IDLE: begin
                    if (vld_nxt) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        state <= IDLE;
                        ptr   <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 4 and hold limit disabled)
// share one stimulus stream and are compared against a behavioural model.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       done = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    rr_arbiter8_if if4 ();
    rr_arbiter8_if if0 ();

    assign if4.req  = req;
    assign if4.mask = mask;
    assign if4.done = done;
    assign if0.req  = req;
    assign if0.mask = mask;
    assign if0.done = done;

    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    rr_arbiter8 #(.MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    always #5 clk = ~clk;

    logic [7:0] o_gnt [2];
    logic [2:0] o_idx [2];
    logic       o_vld [2];
    logic       o_to  [2];

    assign o_gnt[0] = if4.gnt;
    assign o_idx[0] = if4.gnt_idx;
    assign o_vld[0] = if4.gnt_valid;
    assign o_to[0]  = if4.timeout;
    assign o_gnt[1] = if0.gnt;
    assign o_idx[1] = if0.gnt_idx;
    assign o_vld[1] = if0.gnt_valid;
    assign o_to[1]  = if0.timeout;

    // Reference model state, one slot per instance.
    int hold  [2] = '{4, 0};
    int m_busy[2];
    int m_ptr [2];
    int m_idx [2];
    int m_cnt [2];
    int m_to  [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 0; m_ptr[n] = 0; m_idx[n] = 0; m_cnt[n] = 0; m_to[n] = 0;
        end
    endtask

    task automatic model_edge(input int n);
        logic [7:0] eff;
        bit d, dr, t, found;
        eff = req & ~mask;
        if (m_busy[n] == 0) begin
            m_to[n] = 0;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr[n] + k) % 8;
                if (!found && eff[j]) begin
                    found = 1;
                    m_busy[n] = 1;
                    m_idx[n] = j;
                    m_cnt[n] = 0;
                end
            end
        end else begin
            d  = done;
            dr = !eff[m_idx[n]];
            t  = (hold[n] != 0) && (m_cnt[n] == hold[n] - 1);
            if (d || dr || t) begin
                m_busy[n] = 0;
                m_ptr[n]  = (m_idx[n] + 1) % 8;
                m_to[n]   = (t && !d && !dr) ? 1 : 0;
                m_idx[n]  = 0;
            end else begin
                m_cnt[n]++;
                m_to[n] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int n = 0; n < 2; n++) begin
            logic [7:0] eg;
            eg = (m_busy[n] != 0) ? (8'h01 << m_idx[n]) : 8'h00;
            chk($sformatf("gnt[u%0d]", n), o_gnt[n], eg);
            chk($sformatf("gnt_idx[u%0d]", n), o_idx[n], (m_busy[n] != 0) ? m_idx[n] : 0);
            chk($sformatf("gnt_valid[u%0d]", n), o_vld[n], m_busy[n]);
            chk($sformatf("timeout[u%0d]", n), o_to[n], m_to[n]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n_cyc;
        int to_seen;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Reset mid-grant: requester 5 granted, then async reset.
        req = 8'h20;
        cyc();
        chk("grant5", o_idx[0], 5);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", o_gnt[0], 0);
        chk("arst_vld", o_vld[0], 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        req = 8'hFF;
        cyc();
        chk("post_rst_first", o_idx[0], 0);

        // Rotation with done on each grant's first busy cycle.
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            cyc();
            chk("rot_dead", o_vld[0], 0);
            done = 1'b0;
            cyc();
            chk("rot_idx", o_idx[0], k % 8);
        end

        // Wrap with gaps: move ptr to 3, then req 8'b1000_0100.
        req = 8'h04;
        cyc();
        cyc();
        chk("grant2", o_idx[0], 2);
        req = 8'h84;
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("wrap_7", o_idx[0], 7);
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("wrap_2", o_idx[0], 2);

        // Timeout: hold limit 4 on unit 0.
        req = 8'h10;
        cyc();
        cyc();
        chk("to_grant", o_gnt[0], 8'h10);
        n_cyc = 1;
        to_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (o_to[0]) to_seen++;
            if (!o_vld[0]) break;
            n_cyc++;
        end
        chk("hold_len", n_cyc, 4);
        chk("to_pulses", to_seen, 1);
        cyc();
        chk("to_cleared", o_to[0], 0);
        chk("to_regrant", o_gnt[0], 8'h10);

        // Drop/mask: requester 3 granted, others' mask churn, then mask[3].
        req = 8'h08;
        cyc();
        cyc();
        chk("grant3", o_idx[0], 3);
        req = 8'hFF;
        mask = 8'hF7;
        cyc();
        mask = 8'h50;
        cyc();
        chk("mask_other", o_gnt[0], 8'h08);
        mask = 8'h08;
        cyc();
        chk("mask_rel", o_vld[0], 0);
        chk("mask_no_to", o_to[0], 0);

        // Done while idle is ignored and leaves ptr alone (ptr is 4 here).
        req = 8'h00;
        mask = 8'h00;
        done = 1'b1;
        cyc();
        cyc();
        chk("idle_done", o_vld[0], 0);
        done = 1'b0;
        req = 8'hFF;
        cyc();
        chk("idle_ptr", o_idx[0], 4);

        // Randomized traffic with sticky requests so hold limits are reached.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom);
            if ($urandom_range(7) == 0) req = 8'h00;
            mask = 8'($urandom & $urandom & $urandom);
            done = ($urandom_range(5) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
